qq_cmd_frontend: RTL and testbench
==================================

# qq_cmd_frontend

Command front-end for the QuickQ priority queue. It accepts enqueue/dequeue requests from the host over a valid/ready interface and buffers them in a small FIFO. It issues them one at a time to the QuickQ control FSM as single-cycle `enq`/`deq` pulses, waits for completion, and returns one response per command. It sits directly upstream of the control FSM and serialises all queue traffic.

## Interface
- `DATA_W`, 32: key/data width.
- `DEPTH`, 4: command FIFO depth, power of two, ≥2.
- `TIMEOUT`, 255: maximum WAIT cycles before the command is aborted, ≥1.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  host command valid.
- `req_ready`  out  1  FIFO can accept a command.
- `req_op`  in  1  0 = enqueue, 1 = dequeue.
- `req_data`  in  DATA_W  enqueue key (ignored for dequeue).
- `enq`  out  1  one-cycle enqueue strobe to the control FSM.
- `deq`  out  1  one-cycle dequeue strobe to the control FSM.
- `enq_data`  out  DATA_W  key for the current enqueue, held stable from ISSUE through WAIT.
- `q_done`  in  1  control FSM finished the current operation (single-cycle pulse).
- `q_full`  in  1  priority queue full.
- `q_empty`  in  1  priority queue empty.
- `q_deq_data`  in  DATA_W  dequeued key, valid in the cycle `q_done` is high.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  host accepts the response.
- `rsp_data`  out  DATA_W  dequeued key; 0 for enqueue; all-ones on error.
- `rsp_err`  out  1  command rejected (full/empty) or timed out.

## Operation
- FIFO push when `req_valid && req_ready`. `req_ready = (count < DEPTH)`. There is no pass-through when full, even if a pop happens in the same cycle.
- States are IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If the FIFO is non-empty, pop the head into the `cmd_op`/`cmd_data` registers and sample `q_full`/`q_empty`.
  - Enqueue while `q_full`, or dequeue while `q_empty`: set `err`, `rsp_data = '1`, go to RESP. No strobe is issued.
  - Otherwise go to ISSUE.
- ISSUE:
  - Assert exactly one of `enq`/`deq` for one cycle.
  - Clear the timeout counter.
  - Go to WAIT.
- WAIT:
  - Increment the counter each cycle.
  - On `q_done`: capture `q_deq_data` (dequeue) or 0 (enqueue), clear `err`, go to RESP.
  - If the counter reaches TIMEOUT with no `q_done`: `err = 1`, `rsp_data = '1`, go to RESP.
  - A late `q_done` outside WAIT is ignored.
- RESP:
  - Hold `rsp_valid`, `rsp_data` and `rsp_err` stable until `rsp_ready`.
  - On the handshake, go to IDLE.
- Commands are processed strictly in order, with one outstanding at a time.
- Counter width is `$clog2(TIMEOUT+1)` and it saturates. FIFO pointers are `$clog2(DEPTH)` bits and wrap naturally. Count is `$clog2(DEPTH)+1` bits.

## Timing
- Reset values:
  - state IDLE, FIFO empty, `req_ready = 1`.
  - `enq = deq = 0`, `enq_data = 0`.
  - `rsp_valid = 0`, `rsp_data = 0`, `rsp_err = 0`.
- Reset mid-operation:
  - Any in-flight command and all buffered commands are discarded.
  - Strobes are low in the cycle after `rst` is sampled.
- Latency, request accepted at cycle t into an empty FIFO with the FSM in IDLE:
  - pop at t+1;
  - `enq`/`deq` high at t+2;
  - WAIT from t+3;
  - `rsp_valid` one cycle after `q_done`.
- Error path: `rsp_valid` at t+2.
- `enq`, `deq`, `rsp_*` and `req_ready` are registered outputs or decoded from registered state. There is no combinational path from `q_done` or `rsp_ready` to any output.
- Simultaneous FIFO push and pop is allowed when `count < DEPTH`; the count is unchanged.

## Structure
- `qq_pkg` holds:
  - `qq_op_t` (`QQ_ENQ = 1'b0`, `QQ_DEQ = 1'b1`);
  - `fe_state_t` (one-hot, 4 bits);
  - `QQ_EMPTY_KEY = '1`, the sentinel shared with the control FSM's empty-slot fill value.
- One sub-module, `qq_cmd_fifo`, holds the parameterised synchronous FIFO (storage `{op, data}`, count-based full/empty).
- `qq_cmd_frontend` instantiates the FIFO and contains the FSM, the command registers and the timeout counter.

## Test plan
- Enqueue 0x10; model returns `q_done` 3 cycles after `enq` → exactly one `enq` pulse with `enq_data = 0x10`; response `{data 0, err 0}`.
- Enqueue 0x30, 0x20, then dequeue, issued back-to-back; model returns 0x20 on the dequeue → three in-order responses, the last `{0x20, 0}`.
- Dequeue with `q_empty = 1` → no `deq` pulse; response `{0xFFFFFFFF, 1}` at t+2.
- Push 5 commands with DEPTH = 4 while the model stalls `q_done` → `req_ready` low after 4 are buffered; the fifth is accepted only after a pop; no loss, no duplicates.
- Model never asserts `q_done`, TIMEOUT = 8 → response `{0xFFFFFFFF, 1}` after 8 WAIT cycles; `rsp_ready` held low for 5 cycles keeps `rsp_*` stable.
- Assert `rst` during WAIT with 2 commands buffered → all outputs return to reset values; FIFO empty; no `enq`/`deq` pulse afterwards.

Source files
------------

// File: rtl/qq_pkg.sv
// ---------------------------------------------------------------------------
// qq_pkg
//   Types and constants shared by the QuickQ command front-end and the
//   control FSM it feeds.
//   - qq_op_t      : host command opcode (enqueue / dequeue)
//   - fe_state_t   : one-hot state encoding of the front-end FSM
//   - QQ_EMPTY_KEY : all-ones key; the same value the control FSM uses to
//                    fill empty slots, reused here as the error response.
// ---------------------------------------------------------------------------
package qq_pkg;

   typedef enum logic {
      QQ_ENQ = 1'b0,
      QQ_DEQ = 1'b1
   } qq_op_t;

   typedef enum logic [3:0] {
      FE_IDLE  = 4'b0001,
      FE_ISSUE = 4'b0010,
      FE_WAIT  = 4'b0100,
      FE_RESP  = 4'b1000
   } fe_state_t;

   // Widest key supported; users slice the low DATA_W bits (DATA_W <= 64).
   localparam int unsigned QQ_MAX_KEY_W = 64;
   localparam logic [QQ_MAX_KEY_W-1:0] QQ_EMPTY_KEY = '1;

endpackage

// File: rtl/qq_cmd_fifo.sv
// ---------------------------------------------------------------------------
// qq_cmd_fifo
//   Synchronous show-ahead FIFO of host commands ({op, data}).
//   Full/empty are derived from an occupancy count. A push while full is
//   dropped even if a pop happens in the same cycle (no pass-through).
// Ports
//   clk, rst        : clock, synchronous active-high reset (empties FIFO)
//   push, push_op,
//   push_data       : write request and command payload
//   pop             : consume the head entry (ignored when empty)
//   head_op,
//   head_data       : current head entry, valid while !empty
//   full, empty     : occupancy flags
// ---------------------------------------------------------------------------
module qq_cmd_fifo
   import qq_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  qq_op_t            push_op,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output qq_op_t            head_op,
   output logic [DATA_W-1:0] head_data,
   output logic              full,
   output logic              empty
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

   logic [DATA_W:0]   mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PW:0]       count_q, count_d;
   logic              do_push, do_pop;

   assign full      = (count_q == DEPTH_C);
   assign empty     = (count_q == '0);
   assign do_push   = push && !full;
   assign do_pop    = pop && !empty;
   assign head_op   = qq_op_t'(mem_q[rd_ptr_q][DATA_W]);
   assign head_data = mem_q[rd_ptr_q][DATA_W-1:0];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // Pointers are log2(DEPTH) bits and wrap on their own.
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (PW+1)'(1);
         2'b01:   count_d = count_q - (PW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only read while count_q says valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= {push_op, push_data};
   end

endmodule

// File: rtl/qq_cmd_frontend.sv
// ---------------------------------------------------------------------------
// qq_cmd_frontend
//   Serialising command front-end for the QuickQ priority queue. Host
//   commands are buffered in qq_cmd_fifo, then issued one at a time to the
//   control FSM as single-cycle enq/deq strobes. Each command produces
//   exactly one response, in command order.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
//   valid && ready. The source holds valid and its payload stable until the
//   transfer; ready may be any value and does not depend on valid.
//   req_*  : host -> front-end (req_ready = FIFO not full)
//   rsp_*  : front-end -> host (rsp_valid held with stable data/err)
//
// Ports
//   clk, rst                        : clock, synchronous active-high reset
//   req_valid/req_ready/req_op/
//   req_data                        : host command (op 0 = enq, 1 = deq)
//   enq, deq, enq_data              : strobes and key to the control FSM
//   q_done, q_full, q_empty,
//   q_deq_data                      : status from the control FSM
//   rsp_valid/rsp_ready/rsp_data/
//   rsp_err                         : response to the host
// ---------------------------------------------------------------------------
module qq_cmd_frontend
   import qq_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_op,
   input  logic [DATA_W-1:0] req_data,
   output logic              enq,
   output logic              deq,
   output logic [DATA_W-1:0] enq_data,
   input  logic              q_done,
   input  logic              q_full,
   input  logic              q_empty,
   input  logic [DATA_W-1:0] q_deq_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]     TIMEOUT_C = CW'(TIMEOUT);
   localparam logic [DATA_W-1:0] ERR_KEY   = QQ_EMPTY_KEY[DATA_W-1:0];

   fe_state_t         state_q, state_d;
   qq_op_t            cmd_op_q, cmd_op_d;
   logic [DATA_W-1:0] cmd_data_q, cmd_data_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic              rsp_err_q, rsp_err_d;

   qq_op_t            fifo_op;
   logic [DATA_W-1:0] fifo_data;
   logic              fifo_full, fifo_empty, fifo_pop;

   qq_cmd_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (req_valid),
      .push_op   (qq_op_t'(req_op)),
      .push_data (req_data),
      .pop       (fifo_pop),
      .head_op   (fifo_op),
      .head_data (fifo_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // All host/FSM-facing outputs decode from registered state only.
   assign req_ready = !fifo_full;
   assign enq       = (state_q == FE_ISSUE) && (cmd_op_q == QQ_ENQ);
   assign deq       = (state_q == FE_ISSUE) && (cmd_op_q == QQ_DEQ);
   assign enq_data  = cmd_data_q;
   assign rsp_valid = (state_q == FE_RESP);
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;

   always_comb begin
      state_d    = state_q;
      cmd_op_d   = cmd_op_q;
      cmd_data_d = cmd_data_q;
      cnt_d      = cnt_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      fifo_pop   = 1'b0;

      case (state_q)
         FE_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               cmd_op_d   = fifo_op;
               cmd_data_d = fifo_data;
               // Commands the queue cannot honour right now are rejected
               // without ever strobing the control FSM.
               if ((fifo_op == QQ_ENQ && q_full) ||
                   (fifo_op == QQ_DEQ && q_empty)) begin
                  rsp_err_d  = 1'b1;
                  rsp_data_d = ERR_KEY;
                  state_d    = FE_RESP;
               end else begin
                  state_d = FE_ISSUE;
               end
            end
         end

         FE_ISSUE: begin
            cnt_d   = '0;
            state_d = FE_WAIT;
         end

         FE_WAIT: begin
            if (cnt_q != TIMEOUT_C) cnt_d = cnt_q + CW'(1);
            // A completion in the last allowed WAIT cycle still wins over
            // the timeout.
            if (q_done) begin
               rsp_data_d = (cmd_op_q == QQ_DEQ) ? q_deq_data : '0;
               rsp_err_d  = 1'b0;
               state_d    = FE_RESP;
            end else if (cnt_d == TIMEOUT_C) begin
               rsp_data_d = ERR_KEY;
               rsp_err_d  = 1'b1;
               state_d    = FE_RESP;
            end
         end

         FE_RESP: begin
            if (rsp_ready) state_d = FE_IDLE;
         end

         default: state_d = FE_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= FE_IDLE;
         cmd_op_q   <= QQ_ENQ;
         cmd_data_q <= '0;
         cnt_q      <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cmd_op_q   <= cmd_op_d;
         cmd_data_q <= cmd_data_d;
         cnt_q      <= cnt_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

endmodule

// File: tb/tb_qq_cmd_frontend.sv
// ---------------------------------------------------------------------------
// tb_qq_cmd_frontend
//   Bench for qq_cmd_frontend with a behavioural control-FSM responder
//   (min-priority queue, programmable q_done delay) and a scoreboard of
//   expected strobes and responses.
// ---------------------------------------------------------------------------
module tb_qq_cmd_frontend;

   localparam int DATA_W  = 32;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 8;
   localparam logic [DATA_W-1:0] ONES = '1;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_valid, req_ready, req_op;
   logic [DATA_W-1:0] req_data;
   logic              enq, deq;
   logic [DATA_W-1:0] enq_data;
   logic              q_done, q_full, q_empty;
   logic [DATA_W-1:0] q_deq_data;
   logic              rsp_valid, rsp_ready, rsp_err;
   logic [DATA_W-1:0] rsp_data;

   int checks = 0;
   int errors = 0;

   logic [DATA_W:0]   exp_q[$];        // {err, data}
   logic [DATA_W:0]   exp_strobe_q[$]; // {op, key (0 for deq)}
   logic [DATA_W-1:0] ref_pq[$];       // expected downstream queue contents
   logic [DATA_W-1:0] mdl_pq[$];       // responder's queue contents

   bit mon_en     = 1'b1;
   bit model_en   = 1'b1;
   int done_delay = 3;
   int last_wait  = 0;

   always #5 clk = ~clk;

   qq_cmd_frontend #(
      .DATA_W  (DATA_W),
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_data   (req_data),
      .enq        (enq),
      .deq        (deq),
      .enq_data   (enq_data),
      .q_done     (q_done),
      .q_full     (q_full),
      .q_empty    (q_empty),
      .q_deq_data (q_deq_data),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err)
   );

   // Control FSM responder: sees a strobe, acts on its queue, pulses q_done.
   initial begin
      q_done     = 1'b0;
      q_deq_data = '0;
      forever begin
         @(negedge clk);
         q_done = 1'b0;
         if (!rst && model_en && (enq || deq)) begin
            if (enq) begin
               mdl_pq.push_back(enq_data);
               q_deq_data = 32'hDEAD_BEEF;
            end else if (mdl_pq.size() == 0) begin
               q_deq_data = 32'hDEAD_BEEF;
            end else begin
               int mi;
               mi = 0;
               for (int i = 1; i < mdl_pq.size(); i++)
                  if (mdl_pq[i] < mdl_pq[mi]) mi = i;
               q_deq_data = mdl_pq[mi];
               mdl_pq.delete(mi);
            end
            repeat (done_delay) @(negedge clk);
            q_done = 1'b1;
         end
      end
   end

   // Monitor: strobe shape/content, response content, response stability.
   initial begin
      logic            prev_strobe;
      logic            prev_hold;
      logic [DATA_W:0] prev_rsp;
      logic [DATA_W:0] e;
      prev_strobe = 1'b0;
      prev_hold   = 1'b0;
      prev_rsp    = '0;
      forever begin
         @(negedge clk);
         #1;
         if (mon_en && !rst) begin
            if (enq || deq) begin
               checks++;
               if ((enq && deq) || prev_strobe) begin
                  errors++;
                  $display("FAIL strobe_shape: enq=%0b deq=%0b prev=%0b, required one strobe for one cycle",
                           enq, deq, prev_strobe);
               end
               checks++;
               if (exp_strobe_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_strobe: enq=%0b deq=%0b key=%h, required none", enq, deq, enq_data);
               end else begin
                  e = exp_strobe_q.pop_front();
                  if ({deq, (enq ? enq_data : 32'h0)} !== e) begin
                     errors++;
                     $display("FAIL strobe_content: got op=%0b key=%h, required op=%0b key=%h",
                              deq, enq_data, e[DATA_W], e[DATA_W-1:0]);
                  end
               end
            end
            if (prev_hold) begin
               checks++;
               if (rsp_valid !== 1'b1 || {rsp_err, rsp_data} !== prev_rsp) begin
                  errors++;
                  $display("FAIL rsp_stable: got valid=%0b err=%0b data=%h, required valid=1 err=%0b data=%h",
                           rsp_valid, rsp_err, rsp_data, prev_rsp[DATA_W], prev_rsp[DATA_W-1:0]);
               end
            end
            if (rsp_valid && rsp_ready) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_rsp: err=%0b data=%h, required none", rsp_err, rsp_data);
               end else begin
                  e = exp_q.pop_front();
                  if ({rsp_err, rsp_data} !== e) begin
                     errors++;
                     $display("FAIL rsp_content: got err=%0b data=%h, required err=%0b data=%h",
                              rsp_err, rsp_data, e[DATA_W], e[DATA_W-1:0]);
                  end
               end
            end
         end
         prev_strobe = enq | deq;
         prev_hold   = rsp_valid && !rsp_ready && !rst;
         prev_rsp    = {rsp_err, rsp_data};
      end
   end

   // kind: 0 normal, 1 rejected (no strobe), 2 untracked, 3 timed out.
   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send_cmd(input logic op, input logic [DATA_W-1:0] data, input int kind);
      int n;
      req_valid = 1'b1;
      req_op    = op;
      req_data  = data;
      n = 0;
      while (!req_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      last_wait = n;
      checks++;
      if (!req_ready) begin
         errors++;
         $display("FAIL req_accept: req_ready=%0b after %0d cycles, required 1", req_ready, n);
      end
      if (kind == 0) begin
         if (op == 1'b0) begin
            ref_pq.push_back(data);
            exp_strobe_q.push_back({1'b0, data});
            exp_q.push_back({1'b0, 32'h0});
         end else begin
            int mi;
            logic [DATA_W-1:0] m;
            mi = 0;
            for (int i = 1; i < ref_pq.size(); i++)
               if (ref_pq[i] < ref_pq[mi]) mi = i;
            m = ref_pq[mi];
            ref_pq.delete(mi);
            exp_strobe_q.push_back({1'b1, 32'h0});
            exp_q.push_back({1'b0, m});
         end
      end else if (kind == 1) begin
         exp_q.push_back({1'b1, ONES});
      end else if (kind == 3) begin
         exp_strobe_q.push_back({op, (op ? 32'h0 : data)});
         exp_q.push_back({1'b1, ONES});
      end
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || exp_strobe_q.size() != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0 || exp_strobe_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d responses and %0d strobes outstanding, required 0",
                  exp_q.size(), exp_strobe_q.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = 1'b0; req_op = 1'b0; req_data = '0;
      q_full = 1'b0; q_empty = 1'b0; rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({req_ready, enq, deq, rsp_valid, rsp_err} !== 5'b10000) begin
         errors++;
         $display("FAIL reset_flags: {ready,enq,deq,rsp_valid,rsp_err}=%b, required 10000",
                  {req_ready, enq, deq, rsp_valid, rsp_err});
      end
      checks++;
      if (enq_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_enq_data: got %h, required 0", enq_data);
      end
      checks++;
      if (rsp_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_rsp_data: got %h, required 0", rsp_data);
      end
   endtask

   task automatic test_enqueue();
      done_delay = 3;
      send_cmd(1'b0, 32'h10, 0);
      checks++;
      if (enq !== 1'b0 || deq !== 1'b0) begin
         errors++;
         $display("FAIL enq_early: enq=%0b deq=%0b at t+1, required 0 0", enq, deq);
      end
      @(negedge clk);
      checks++;
      if (enq !== 1'b1 || deq !== 1'b0 || enq_data !== 32'h10) begin
         errors++;
         $display("FAIL enq_latency: enq=%0b deq=%0b key=%h at t+2, required 1 0 00000010", enq, deq, enq_data);
      end
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         checks++;
         if (rsp_valid !== 1'b0 || enq_data !== 32'h10) begin
            errors++;
            $display("FAIL enq_wait: cycle %0d rsp_valid=%0b key=%h, required 0 00000010", i, rsp_valid, enq_data);
         end
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1) begin
         errors++;
         $display("FAIL rsp_latency: rsp_valid=%0b one cycle after q_done, required 1", rsp_valid);
      end
      wait_drain(50);
   endtask

   task automatic test_back_to_back();
      ref_pq.delete();
      mdl_pq.delete();
      done_delay = 3;
      send_cmd(1'b0, 32'h30, 0);
      send_cmd(1'b0, 32'h20, 0);
      send_cmd(1'b1, 32'h0, 0);
      wait_drain(100);
   endtask

   task automatic test_rejects();
      q_empty = 1'b1;
      send_cmd(1'b1, 32'h0, 1);
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL err_early: rsp_valid=%0b at t+1, required 0", rsp_valid);
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || deq !== 1'b0 || enq !== 1'b0) begin
         errors++;
         $display("FAIL err_empty_latency: rsp_valid=%0b enq=%0b deq=%0b at t+2, required 1 0 0", rsp_valid, enq, deq);
      end
      wait_drain(20);
      q_empty = 1'b0;
      q_full  = 1'b1;
      send_cmd(1'b0, 32'h55, 1);
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || enq !== 1'b0) begin
         errors++;
         $display("FAIL err_full_latency: rsp_valid=%0b enq=%0b at t+2, required 1 0", rsp_valid, enq);
      end
      wait_drain(20);
      q_full = 1'b0;
   endtask

   task automatic test_backpressure();
      ref_pq.delete();
      mdl_pq.delete();
      done_delay = 6;
      for (int i = 0; i < 5; i++)
         send_cmd(1'b0, 32'($urandom_range(1, 500)), 0);
      checks++;
      if (req_ready !== 1'b0) begin
         errors++;
         $display("FAIL fifo_full: req_ready=%0b with 4 buffered, required 0", req_ready);
      end
      send_cmd(1'b0, 32'($urandom_range(1, 500)), 0);
      checks++;
      if (last_wait == 0) begin
         errors++;
         $display("FAIL fifo_stall: sixth command waited %0d cycles, required >0", last_wait);
      end
      send_cmd(1'b1, 32'h0, 0);
      send_cmd(1'b1, 32'h0, 0);
      wait_drain(400);
   endtask

   task automatic test_done_boundary();
      done_delay = TIMEOUT;
      send_cmd(1'b0, 32'h42, 0);
      wait_drain(60);
   endtask

   task automatic test_timeout();
      model_en  = 1'b0;
      rsp_ready = 1'b0;
      send_cmd(1'b0, 32'h77, 3);
      @(negedge clk);
      for (int i = 1; i <= TIMEOUT; i++) begin
         @(negedge clk);
         checks++;
         if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: rsp_valid=%0b in WAIT cycle %0d, required 0", rsp_valid, i);
         end
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== ONES) begin
         errors++;
         $display("FAIL timeout_rsp: valid=%0b err=%0b data=%h, required 1 1 ffffffff", rsp_valid, rsp_err, rsp_data);
      end
      repeat (5) @(negedge clk);
      rsp_ready = 1'b1;
      wait_drain(20);
      model_en = 1'b1;
   endtask

   task automatic test_reset_mid();
      int bad;
      mon_en   = 1'b0;
      model_en = 1'b0;
      send_cmd(1'b0, 32'hA1, 2);
      send_cmd(1'b0, 32'hA2, 2);
      send_cmd(1'b1, 32'h0, 2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({req_ready, enq, deq, rsp_valid, rsp_err} !== 5'b10000 || enq_data !== 32'h0 || rsp_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_mid: {ready,enq,deq,valid,err}=%b key=%h data=%h, required 10000 0 0",
                  {req_ready, enq, deq, rsp_valid, rsp_err}, enq_data, rsp_data);
      end
      bad = 0;
      repeat (15) begin
         @(negedge clk);
         if (enq || deq || rsp_valid || !req_ready) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL reset_flush: %0d active cycles after reset, required 0", bad);
      end
      exp_q.delete();
      exp_strobe_q.delete();
      ref_pq.delete();
      mdl_pq.delete();
      mon_en   = 1'b1;
      model_en = 1'b1;
      done_delay = 2;
      send_cmd(1'b0, 32'h99, 0);
      send_cmd(1'b1, 32'h0, 0);
      wait_drain(60);
   endtask

   task automatic test_random();
      ref_pq.delete();
      mdl_pq.delete();
      for (int i = 0; i < 24; i++) begin
         done_delay = $urandom_range(1, TIMEOUT - 1);
         if (ref_pq.size() != 0 && $urandom_range(0, 2) == 0)
            send_cmd(1'b1, 32'($urandom), 0);
         else
            send_cmd(1'b0, 32'($urandom_range(1, 100000)), 0);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_drain(800);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_enqueue();
      test_back_to_back();
      test_rejects();
      test_backpressure();
      test_done_boundary();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
